multiplier_hilo: RTL and testbench

MULTIPLIER_HILO -- requirements
Module: multiplier_hilo

---
 rtl/multiplier_hilo.sv | 142 ++++++++++++++
 tb/tb_multiplier_hilo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_hilo.sv
// Unsigned shift-add multiplier writing a 2*WIDTH product into HI/LO, read back via MFHI/MFLO.
// Optional macro MULTIPLIER_HILO_EARLY_EXIT_EN ends RUN once the remaining multiplier bits are all zero.
module multiplier_hilo #(
  parameter int unsigned WIDTH = 32,
  parameter logic [5:0]  MULTU = 6'b011001,
  parameter logic [5:0]  MFHI  = 6'b010000,
  parameter logic [5:0]  MFLO  = 6'b010010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [5:0]           prev_sig_q, prev_sig_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 start;
  logic                 run_last;
  logic [WIDTH-1:0]     mplier_shift;
  logic [CW-1:0]        cnt_inc;

  // Edge-detect on the opcode so a held MULTU launches only one multiply.
  assign start        = (Signal == MULTU) && (prev_sig_q != MULTU);
  assign mplier_shift = mplier_q >> 1;
  assign cnt_inc      = cnt_q + CW'(1);

`ifdef MULTIPLIER_HILO_EARLY_EXIT_EN
  assign run_last = (cnt_inc == CNT_LAST) || (mplier_shift == '0);
`else
  assign run_last = (cnt_inc == CNT_LAST);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      prev_sig_q <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_sig_q <= prev_sig_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prev_sig_d = Signal;
    hi_d       = hi_q;
    lo_d       = lo_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, dataA};
          mplier_d = dataB;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shift;
        cnt_d    = cnt_inc;
        if (run_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        hi_d    = acc_q[2*WIDTH-1:WIDTH];
        lo_d    = acc_q[WIDTH-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // HI/LO reads are combinational and always show the last committed result.
  always_comb begin
    dataOut = '0;
    if (Signal == MFHI) begin
      dataOut = hi_q;
    end else if (Signal == MFLO) begin
      dataOut = lo_q;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_multiplier_hilo.sv
// Self-checking bench for multiplier_hilo: constant vector table, random operands, and hand-built corner sequences.
module tb_multiplier_hilo;
  localparam int W = 32;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_ALU   = 6'h20;
  localparam logic [5:0] OP_NOP   = 6'h3F;

  logic         clk = 1'b0;
  logic         reset;
  logic [5:0]   Signal;
  logic [W-1:0] dataA, dataB, dataOut;
  logic         busy, done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  multiplier_hilo dut (
    .clk    (clk),
    .reset  (reset),
    .Signal (Signal),
    .dataA  (dataA),
    .dataB  (dataB),
    .dataOut(dataOut),
    .busy   (busy),
    .done   (done)
  );

  // Edges from the start edge to the done pulse.
  function automatic int exp_lat(logic [31:0] b);
`ifdef MULTIPLIER_HILO_EARLY_EXIT_EN
    int n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n + 1;
`else
    return W + 1;
`endif
  endfunction

  function automatic logic [63:0] ref_prod(logic [31:0] a, logic [31:0] b);
    logic [63:0] x, y;
    x = {32'b0, a};
    y = {32'b0, b};
    return x * y;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic read_hilo(input string nm, input logic [63:0] exp);
    Signal = OP_MFLO;
    #1 chk({nm, "_lo"}, 64'(dataOut), 64'(exp[31:0]));
    Signal = OP_MFHI;
    #1 chk({nm, "_hi"}, 64'(dataOut), 64'(exp[63:32]));
    Signal = OP_ALU;
  endtask

  // Called just after a falling edge; the next rising edge is the start edge.
  task automatic do_mul(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int lat;
    Signal = OP_MULTU;
    dataA  = a;
    dataB  = b;
    lat    = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk({nm, "_busy"}, 64'(busy), 64'd1);
        Signal = OP_ALU;
        dataA  = $urandom;
        dataB  = $urandom;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    chk({nm, "_lat"}, 64'(lat), 64'(exp_lat(b)));
    @(negedge clk);
    chk({nm, "_done_pulse"}, 64'({done, busy}), 64'd0);
    read_hilo(nm, exp);
  endtask

  initial begin
    int pulses, first, lat;
    logic [31:0] a, b;
    logic [63:0] prior;

    tbl[0] = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F};
    tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    tbl[2] = '{32'h0000_0000, 32'hDEAD_BEEF, 64'h0000_0000_0000_0000};
    tbl[3] = '{32'hDEAD_BEEF, 32'h0000_0000, 64'h0000_0000_0000_0000};
    tbl[4] = '{32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780};
    tbl[5] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
    tbl[6] = '{32'h0000_0007, 32'h0000_0001, 64'h0000_0000_0000_0007};

    reset  = 1'b1;
    Signal = '0;
    dataA  = '0;
    dataB  = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy_done", 64'({busy, done}), 64'd0);
    read_hilo("reset", 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      do_mul($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].prod);
    end

    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      do_mul($sformatf("rnd%0d", i), a, b, ref_prod(a, b));
    end

    // Opcode held for 40 edges: one multiply, operand changes at k+5 ignored.
    a = 32'h0000_1234;
    b = 32'h0000_5678;
    Signal = OP_MULTU;
    dataA  = a;
    dataB  = b;
    pulses = 0;
    first  = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (i == 4) begin
        dataA = 32'hFFFF_FFFF;
        dataB = 32'hFFFF_FFFF;
      end
      if (i == 39) Signal = OP_ALU;
    end
    chk("stuck_pulses", 64'(pulses), 64'd1);
    chk("stuck_lat", 64'(first), 64'(exp_lat(b)));
    read_hilo("stuck", 64'h0000_0000_0626_0060);

    // Reset at edge k+10 aborts with no write and no done.
    a = 32'h1234_5678;
`ifdef MULTIPLIER_HILO_EARLY_EXIT_EN
    b = 32'h8000_0010;
`else
    b = 32'h0000_0010;
`endif
    Signal = OP_MULTU;
    dataA  = a;
    dataB  = b;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) Signal = OP_ALU;
      if (i == 9) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy_done", 64'({busy, done}), 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("abort_quiet", 64'(pulses), 64'd0);
    read_hilo("abort", 64'd0);

    // Reset and start together: reset wins, then the held MULTU starts after release.
    reset  = 1'b1;
    Signal = OP_MULTU;
    dataA  = 32'd5;
    dataB  = 32'd6;
    @(negedge clk);
    chk("rst_start_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    do_mul("post_reset", 32'd5, 32'd6, 64'd30);

    // Reads while busy return the previous HI/LO.
    do_mul("prep", 32'h8000_0001, 32'h0000_0002, 64'h0000_0001_0000_0002);
    a = 32'h0000_0007;
    b = 32'hFFFF_FFFF;
    Signal = OP_MULTU;
    dataA  = a;
    dataB  = b;
    lat    = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) Signal = OP_ALU;
      if (i == 10) begin
        Signal = OP_MFHI;
        #1 chk("busy_read_hi", 64'(dataOut), 64'h1);
        Signal = OP_MFLO;
        #1 chk("busy_read_lo", 64'(dataOut), 64'h2);
        Signal = OP_ALU;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("busy_read_lat", 64'(lat), 64'(exp_lat(b)));
    @(negedge clk);
    read_hilo("after_busy", ref_prod(a, b));

    // Opcode 0x3F does nothing.
    prior  = ref_prod(a, b);
    Signal = OP_NOP;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy || done) pulses++;
    end
    chk("nop_quiet", 64'(pulses), 64'd0);
    chk("nop_dataout", 64'(dataOut), 64'd0);
    read_hilo("nop", prior);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
